// File: rtl/reg_file_pkg.sv
// Shared constants and lane-merge helper for the architectural register file.
// Latency: n/a (package only).
// Backpressure: n/a.
package reg_file_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 32;
    localparam int MAX_WIDTH     = 256;
    localparam int MAX_NB        = MAX_WIDTH / 8;

    // Callers zero-extend into MAX_WIDTH and truncate the result back to their own width.
    function automatic logic [MAX_WIDTH-1:0] merge_lanes(
        input logic [MAX_WIDTH-1:0] old_word,
        input logic [MAX_WIDTH-1:0] new_word,
        input logic [MAX_NB-1:0]    byte_en
    );
        logic [MAX_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_NB; i++) begin
            if (byte_en[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// Write-back/decode bus of the register file: one write port, two read ports.
// Latency: reads combinational, write takes effect at the next rising edge.
// Backpressure: none; every write is accepted.
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) ();
    localparam int AW = $clog2(DEPTH);
    localparam int NB = WIDTH / 8;

    logic             we;
    logic [AW-1:0]    waddr;
    logic [NB-1:0]    wbe;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    raddr_a;
    logic [WIDTH-1:0] rdata_a;
    logic [AW-1:0]    raddr_b;
    logic [WIDTH-1:0] rdata_b;

    modport master (
        output we, waddr, wbe, wdata, raddr_a, raddr_b,
        input  rdata_a, rdata_b
    );

    modport slave (
        input  we, waddr, wbe, wdata, raddr_a, raddr_b,
        output rdata_a, rdata_b
    );
endinterface

// File: rtl/reg_file_lane.sv
// One byte of one register entry, with synchronous clear taking priority over load.
// Latency: load visible one edge later.
// Backpressure: none.
module reg_file_lane (
    input  logic       clk,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] d,
    output logic [7:0] q
);
    logic [7:0] val_q;
    logic [7:0] val_d;

    always_comb begin
        val_d = val_q;
        if (load) val_d = d;
    end

    always_ff @(posedge clk) begin
        if (clear) val_q <= '0;
        else       val_q <= val_d;
    end

    assign q = val_q;
endmodule

// File: rtl/reg_file.sv
// Architectural register file: DEPTH x WIDTH, entry 0 hardwired to zero, byte-enabled writes.
// Latency: reads 0 cycles, writes 1 edge; REGFILE_BYPASS_EN forwards the in-flight write to reads.
// Backpressure: none; writes always complete, clear beats a same-edge write.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic      clk,
    input  logic      clear,
    reg_file_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] words [DEPTH];
    logic [AW-1:0]    waddr;
    logic             wr_act;
    logic [WIDTH-1:0] wr_merged;

    assign waddr = bus.waddr;

    // The same merged word feeds the lane flops and the forwarding path.
    always_comb begin
        wr_act    = bus.we && !clear && (waddr != '0);
        wr_merged = WIDTH'(merge_lanes(MAX_WIDTH'(words[waddr]),
                                       MAX_WIDTH'(bus.wdata),
                                       MAX_NB'(bus.wbe)));
    end

    assign words[0] = '0;

    for (genvar e = 1; e < DEPTH; e++) begin : g_entry
        logic [WIDTH-1:0] entry_q;
        for (genvar b = 0; b < NB; b++) begin : g_lane
            reg_file_lane u_lane (
                .clk   (clk),
                .clear (clear),
                .load  (wr_act && (waddr == AW'(e))),
                .d     (wr_merged[8*b +: 8]),
                .q     (entry_q[8*b +: 8])
            );
        end
        assign words[e] = entry_q;
    end

    logic [WIDTH-1:0] stored_a;
    logic [WIDTH-1:0] stored_b;

    assign stored_a = words[bus.raddr_a];
    assign stored_b = words[bus.raddr_b];

`ifdef REGFILE_BYPASS_EN
    assign bus.rdata_a = (wr_act && (bus.raddr_a == waddr)) ? wr_merged : stored_a;
    assign bus.rdata_b = (wr_act && (bus.raddr_b == waddr)) ? wr_merged : stored_b;
`else
    assign bus.rdata_a = stored_a;
    assign bus.rdata_b = stored_b;
`endif
endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: clear, full/partial writes, address 0, clear priority, forwarding.
module tb_reg_file;
    logic clk;
    logic clear;
    int   checks;
    int   failures;

    reg_file_if #(.WIDTH(32), .DEPTH(32)) bus ();

    reg_file #(.WIDTH(32), .DEPTH(32)) u_dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.we    = 1'b0;
        bus.waddr = '0;
        bus.wbe   = '0;
        bus.wdata = '0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
        bus.we    = 1'b1;
        bus.waddr = a;
        bus.wbe   = be;
        bus.wdata = d;
        tick();
        idle_bus();
    endtask

    task automatic test_reset();
        clear = 1'b1;
        idle_bus();
        tick();
        clear = 1'b0;
        for (int a = 0; a < 32; a++) begin
            bus.raddr_a = 5'(a);
            bus.raddr_b = 5'(31 - a);
            #1;
            checks++;
            if (bus.rdata_a !== 32'h0) begin
                failures++;
                $display("FAIL reset_a[%0d]: got %h expected %h", a, bus.rdata_a, 32'h0);
            end
            checks++;
            if (bus.rdata_b !== 32'h0) begin
                failures++;
                $display("FAIL reset_b[%0d]: got %h expected %h", 31 - a, bus.rdata_b, 32'h0);
            end
        end
    endtask

    task automatic test_full_write();
        bus.raddr_a = 5'd5;
        bus.raddr_b = 5'd5;
        do_write(5'd5, 4'hF, 32'hDEADBEEF);
        checks++;
        if (bus.rdata_a !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL full_write_a: got %h expected %h", bus.rdata_a, 32'hDEADBEEF);
        end
        checks++;
        if (bus.rdata_b !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL full_write_b: got %h expected %h", bus.rdata_b, 32'hDEADBEEF);
        end
        bus.raddr_b = 5'd4;
        #1;
        checks++;
        if (bus.rdata_b !== 32'h0) begin
            failures++;
            $display("FAIL neighbour_untouched: got %h expected %h", bus.rdata_b, 32'h0);
        end
    endtask

    task automatic test_partial_write();
        bus.raddr_a = 5'd5;
        do_write(5'd5, 4'b0101, 32'h11223344);
        checks++;
        if (bus.rdata_a !== 32'hDE22BE44) begin
            failures++;
            $display("FAIL partial_write: got %h expected %h", bus.rdata_a, 32'hDE22BE44);
        end
        do_write(5'd5, 4'b0000, 32'hFFFFFFFF);
        checks++;
        if (bus.rdata_a !== 32'hDE22BE44) begin
            failures++;
            $display("FAIL wbe_zero_noop: got %h expected %h", bus.rdata_a, 32'hDE22BE44);
        end
    endtask

    task automatic test_write_zero();
        bus.raddr_a = 5'd0;
        bus.raddr_b = 5'd0;
        do_write(5'd0, 4'hF, 32'hFFFFFFFF);
        checks++;
        if (bus.rdata_a !== 32'h0) begin
            failures++;
            $display("FAIL write_zero_a: got %h expected %h", bus.rdata_a, 32'h0);
        end
        checks++;
        if (bus.rdata_b !== 32'h0) begin
            failures++;
            $display("FAIL write_zero_b: got %h expected %h", bus.rdata_b, 32'h0);
        end
    endtask

    task automatic test_clear_beats_write();
        bus.raddr_a = 5'd7;
        bus.raddr_b = 5'd5;
        clear     = 1'b1;
        do_write(5'd7, 4'hF, 32'h12345678);
        clear     = 1'b0;
        checks++;
        if (bus.rdata_a !== 32'h0) begin
            failures++;
            $display("FAIL clear_beats_write: got %h expected %h", bus.rdata_a, 32'h0);
        end
        checks++;
        if (bus.rdata_b !== 32'h0) begin
            failures++;
            $display("FAIL clear_wipes_entry5: got %h expected %h", bus.rdata_b, 32'h0);
        end
        do_write(5'd7, 4'hF, 32'h12345678);
        checks++;
        if (bus.rdata_a !== 32'h12345678) begin
            failures++;
            $display("FAIL write_after_clear: got %h expected %h", bus.rdata_a, 32'h12345678);
        end
    endtask

    task automatic test_back_to_back();
        bus.raddr_a = 5'd3;
        bus.raddr_b = 5'd7;
        do_write(5'd3, 4'b0001, 32'h000000AA);
        do_write(5'd3, 4'b1000, 32'hBB000000);
        checks++;
        if (bus.rdata_a !== 32'hBB0000AA) begin
            failures++;
            $display("FAIL lane_merge: got %h expected %h", bus.rdata_a, 32'hBB0000AA);
        end
        checks++;
        if (bus.rdata_b !== 32'h12345678) begin
            failures++;
            $display("FAIL port_b_independent: got %h expected %h", bus.rdata_b, 32'h12345678);
        end
        bus.we    = 1'b1;
        bus.waddr = 5'd3;
        bus.wbe   = 4'hF;
        bus.wdata = 32'h11111111;
        tick();
        bus.wdata = 32'h22222222;
        tick();
        idle_bus();
        checks++;
        if (bus.rdata_a !== 32'h22222222) begin
            failures++;
            $display("FAIL last_write_wins: got %h expected %h", bus.rdata_a, 32'h22222222);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_pre;
        do_write(5'd9, 4'hF, 32'hAAAAAAAA);
        bus.raddr_a = 5'd9;
        bus.raddr_b = 5'd9;
        bus.we      = 1'b1;
        bus.waddr   = 5'd9;
        bus.wbe     = 4'b0011;
        bus.wdata   = 32'h00005555;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 32'hAAAA5555;
`else
        exp_pre = 32'hAAAAAAAA;
`endif
        checks++;
        if (bus.rdata_a !== exp_pre) begin
            failures++;
            $display("FAIL bypass_pre_edge_a: got %h expected %h", bus.rdata_a, exp_pre);
        end
        checks++;
        if (bus.rdata_b !== exp_pre) begin
            failures++;
            $display("FAIL bypass_pre_edge_b: got %h expected %h", bus.rdata_b, exp_pre);
        end
        tick();
        idle_bus();
        checks++;
        if (bus.rdata_a !== 32'hAAAA5555) begin
            failures++;
            $display("FAIL bypass_post_edge: got %h expected %h", bus.rdata_a, 32'hAAAA5555);
        end

        // Address 0 is never forwarded.
        bus.raddr_a = 5'd0;
        bus.we      = 1'b1;
        bus.waddr   = 5'd0;
        bus.wbe     = 4'hF;
        bus.wdata   = 32'hFFFFFFFF;
        #1;
        checks++;
        if (bus.rdata_a !== 32'h0) begin
            failures++;
            $display("FAIL bypass_addr0: got %h expected %h", bus.rdata_a, 32'h0);
        end
        tick();
        idle_bus();

        // clear suppresses forwarding, then wipes the entry.
        do_write(5'd10, 4'hF, 32'h01020304);
        bus.raddr_a = 5'd10;
        clear       = 1'b1;
        bus.we      = 1'b1;
        bus.waddr   = 5'd10;
        bus.wbe     = 4'hF;
        bus.wdata   = 32'hFEEDFACE;
        #1;
        checks++;
        if (bus.rdata_a !== 32'h01020304) begin
            failures++;
            $display("FAIL bypass_clear_suppress: got %h expected %h", bus.rdata_a, 32'h01020304);
        end
        tick();
        clear = 1'b0;
        idle_bus();
        checks++;
        if (bus.rdata_a !== 32'h0) begin
            failures++;
            $display("FAIL clear_with_bypass_write: got %h expected %h", bus.rdata_a, 32'h0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        clear       = 1'b0;
        bus.raddr_a = '0;
        bus.raddr_b = '0;
        idle_bus();
        tick();
        test_reset();
        test_full_write();
        test_partial_write();
        test_write_zero();
        test_clear_beats_write();
        test_back_to_back();
        test_bypass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
